cm_cmd_sequencer: RTL and testbench
===================================

# cm_cmd_sequencer

Command sequencer for the CM datapath. Pops bytes from the UART RX FIFO, parses fixed 5-byte command packets and executes them. Commands either write the pixel memory or stage display configuration (Vertical_Split, Horizontal_Split, VGA_debug). Staged configuration is applied only at a frame boundary, detected on the VSync rising edge, so the VGA path never sees a mid-frame change.

## Interface
- ADDR_W, 12, pixel memory address width
- HDR, 8'hA5, packet header byte
- TIMEOUT, 1024, max idle cycles between bytes inside a packet (power of two, ≥ 4)

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- Empty  in  1  RX FIFO empty (first-word-fall-through FIFO)
- RXD_Data  in  8  FIFO head byte; valid while Empty = 0
- Read  out  1  FIFO pop strobe
- VSync  in  1  frame sync from VGA timing
- Vertical_Split  out  1  active config
- Horizontal_Split  out  1  active config
- VGA_debug  out  1  active config
- Mem_WE  out  1  pixel memory write enable
- Mem_Addr  out  ADDR_W  pixel memory write address
- Mem_Data  out  8  pixel memory write data
- Busy  out  1  packet in progress
- Err  out  1  one-cycle error pulse

## Operation
- Packet format: HDR, OP, ARG_HI, ARG_LO, CHK.
  - CHK = OP ^ ARG_HI ^ ARG_LO.
- FSM states: S_HDR → S_OP → S_AHI → S_ALO → S_CHK → S_EXEC → S_HDR.
- S_HDR: each consumed byte ≠ HDR is discarded (resync); stay in S_HDR. A consumed HDR byte → S_OP.
- S_OP, S_AHI, S_ALO: each consumed byte is latched and the FSM advances one state.
- S_CHK: consumed byte compared with computed XOR.
  - Match and OP valid → S_EXEC.
  - Mismatch or unknown OP → Err pulse, → S_HDR, no side effect.
- Opcodes:
  - 0x01 CFG: shadow ← ARG_LO[2:0] = {VGA_debug, Horizontal_Split, Vertical_Split}.
  - 0x02 SET_ADDR: address pointer ← {ARG_HI, ARG_LO}[ADDR_W-1:0].
  - 0x03 WRITE: Mem_WE = 1, Mem_Addr = pointer, Mem_Data = ARG_LO. Pointer increments by 1 after the write, modulo 2^ADDR_W (wraps to 0).
- S_EXEC lasts one cycle, then → S_HDR.
- Frame apply: VSync is registered into vs_q; frame edge = VSync & ~vs_q. On a frame edge the three active config outputs take the current shadow value.
- Timeout: a counter clears on every consumed byte and counts each cycle in S_OP..S_CHK with no byte consumed. When it reaches TIMEOUT-1: Err pulse, → S_HDR, partial packet dropped.
- Busy = (state ≠ S_HDR).

## Timing
- Read is combinational: Read = ~Empty & ~rst & (state ≠ S_EXEC). A byte is consumed at the clk edge where Read = 1. Back-to-back bytes are consumed every cycle.
- Minimum packet time is 6 cycles: 5 consume cycles plus 1 S_EXEC.
- Shadow, pointer (SET_ADDR), Mem_WE/Mem_Addr/Mem_Data, and Err are all registered at the edge that consumes CHK.
  - Mem_WE and Err are high exactly one cycle (the following cycle).
  - For WRITE, the pointer increment occurs at the end of S_EXEC.
- Mem_Addr/Mem_Data hold their last value when Mem_WE = 0.
- Config latency: the frame edge is detected one cycle after VSync rises; outputs update at the next edge.
- Simultaneous CFG and frame edge: if the frame edge and the CHK consume happen in the same cycle, the old shadow is applied and the new value waits for the next frame.
- Reset: all outputs 0; state S_HDR; shadow, pointer, timeout counter, vs_q all 0. Reset mid-packet drops the packet with no Err and no write. Read is 0 while rst = 1.

## Test plan
- Config staging: bytes A5 01 00 05 04, then VSync rising edge → Vertical_Split = 1, Horizontal_Split = 0, VGA_debug = 1 two cycles after VSync rises. Outputs remain 0 before the edge.
- Address and write: A5 02 00 10 12, then A5 03 00 7E 7D → single Mem_WE pulse with Mem_Addr = 0x010, Mem_Data = 0x7E. A second WRITE A5 03 00 33 30 → Mem_Addr = 0x011.
- Wrap-around: A5 02 0F FF F2, then two WRITE packets → writes at 0xFFF, then 0x000.
- Resync and checksum error: bytes 00 FF A5 03 00 11 00 → leading bytes discarded. Err pulses one cycle after the CHK consume; no Mem_WE; the next valid packet executes normally.
- Timeout: A5 01 then Empty held 1 for 1023 cycles → Err pulse, Busy falls. A following full packet executes.
- Reset mid-packet and simultaneous event: assert rst after A5 02 → no write, Busy = 0, pointer = 0. A CFG CHK consumed in the same cycle as a VSync frame edge → old config applied; new config applied on the following frame.

Source files
------------

// File: rtl/cm_cmd_sequencer.sv
// Command sequencer: parses 5-byte packets from an RX FIFO, writes pixel memory
// and stages display config that is applied only on a VSync frame edge.
module cm_cmd_sequencer #(
  parameter int          ADDR_W  = 12,
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter int          TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Empty,
  input  logic [7:0]        RXD_Data,
  output logic              Read,
  input  logic              VSync,
  output logic              Vertical_Split,
  output logic              Horizontal_Split,
  output logic              VGA_debug,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [7:0]        Mem_Data,
  output logic              Busy,
  output logic              Err
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_HDR, S_OP, S_AHI, S_ALO, S_CHK, S_EXEC} state_t;

  state_t              state_q;
  logic [7:0]          op_q, ahi_q, alo_q;
  logic [2:0]          shadow_q, active_q;
  logic [ADDR_W-1:0]   ptr_q, addr_q;
  logic [7:0]          data_q;
  logic                we_q, err_q, vs_q, fe_q;
  logic [TW-1:0]       tmo_q;

  logic                rd_d, in_pkt_d, tmo_hit_d, op_ok_d;
  logic [7:0]          chk_d;

  assign rd_d      = ~Empty & ~rst & (state_q != S_EXEC);
  assign in_pkt_d  = (state_q == S_OP) || (state_q == S_AHI) ||
                     (state_q == S_ALO) || (state_q == S_CHK);
  // Fires on the idle cycle where the counter would reach TIMEOUT-1.
  assign tmo_hit_d = in_pkt_d && !rd_d && (tmo_q == TW'(TIMEOUT - 2));
  assign chk_d     = op_q ^ ahi_q ^ alo_q;
  assign op_ok_d   = (op_q == 8'h01) || (op_q == 8'h02) || (op_q == 8'h03);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HDR;
      op_q     <= '0;
      ahi_q    <= '0;
      alo_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      vs_q     <= 1'b0;
      fe_q     <= 1'b0;
      tmo_q    <= '0;
    end else begin
      vs_q  <= VSync;
      fe_q  <= VSync & ~vs_q;
      // Old shadow wins if a CFG completes on the same edge.
      if (fe_q) active_q <= shadow_q;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      if (rd_d || !in_pkt_d) tmo_q <= '0;
      else                   tmo_q <= tmo_q + 1'b1;

      case (state_q)
        S_HDR: if (rd_d && RXD_Data == HDR) state_q <= S_OP;
        S_OP: begin
          if (rd_d) begin
            op_q    <= RXD_Data;
            state_q <= S_AHI;
          end else if (tmo_hit_d) begin
            err_q   <= 1'b1;
            state_q <= S_HDR;
          end
        end
        S_AHI: begin
          if (rd_d) begin
            ahi_q   <= RXD_Data;
            state_q <= S_ALO;
          end else if (tmo_hit_d) begin
            err_q   <= 1'b1;
            state_q <= S_HDR;
          end
        end
        S_ALO: begin
          if (rd_d) begin
            alo_q   <= RXD_Data;
            state_q <= S_CHK;
          end else if (tmo_hit_d) begin
            err_q   <= 1'b1;
            state_q <= S_HDR;
          end
        end
        S_CHK: begin
          if (rd_d) begin
            if (RXD_Data == chk_d && op_ok_d) begin
              state_q <= S_EXEC;
              case (op_q)
                8'h01:   shadow_q <= alo_q[2:0];
                8'h02:   ptr_q    <= ADDR_W'({ahi_q, alo_q});
                default: begin
                  we_q   <= 1'b1;
                  addr_q <= ptr_q;
                  data_q <= alo_q;
                end
              endcase
            end else begin
              err_q   <= 1'b1;
              state_q <= S_HDR;
            end
          end else if (tmo_hit_d) begin
            err_q   <= 1'b1;
            state_q <= S_HDR;
          end
        end
        S_EXEC: begin
          if (op_q == 8'h03) ptr_q <= ptr_q + 1'b1;
          state_q <= S_HDR;
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign Read             = rd_d;
  assign Vertical_Split   = active_q[0];
  assign Horizontal_Split = active_q[1];
  assign VGA_debug        = active_q[2];
  assign Mem_WE           = we_q;
  assign Mem_Addr         = addr_q;
  assign Mem_Data         = data_q;
  assign Err              = err_q;
  assign Busy             = (state_q != S_HDR);
endmodule

// File: tb/tb_cm_cmd_sequencer.sv
// Directed bench: packets are driven byte by byte; expected writes/errors are
// queued and a negedge monitor pops and compares whenever the DUT shows one.
module tb_cm_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Empty = 1'b1;
  logic [7:0]  RXD_Data = 8'h00;
  logic        VSync = 1'b0;
  logic        Read, Vertical_Split, Horizontal_Split, VGA_debug;
  logic        Mem_WE, Busy, Err;
  logic [11:0] Mem_Addr;
  logic [7:0]  Mem_Data;

  cm_cmd_sequencer dut (
    .clk(clk), .rst(rst), .Empty(Empty), .RXD_Data(RXD_Data), .Read(Read),
    .VSync(VSync), .Vertical_Split(Vertical_Split),
    .Horizontal_Split(Horizontal_Split), .VGA_debug(VGA_debug),
    .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
    .Busy(Busy), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];
  int  eq[$];
  int  n_pass = 0;
  int  n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [2:0] cfg();
    return {VGA_debug, Horizontal_Split, Vertical_Split};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    wr_t w;
    if (!rst) begin
      if (Mem_WE) begin
        if (wq.size() == 0) chk("unexpected Mem_WE", {31'd0, Mem_WE}, 32'd0);
        else begin
          w = wq.pop_front();
          chk("Mem_Addr", {20'd0, Mem_Addr}, {20'd0, w.a});
          chk("Mem_Data", {24'd0, Mem_Data}, {24'd0, w.d});
        end
      end
      if (Err) begin
        if (eq.size() == 0) chk("unexpected Err", {31'd0, Err}, 32'd0);
        else void'(eq.pop_front());
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int   t;
    logic r;
    t = 0;
    Empty = 1'b0;
    RXD_Data = b;
    do begin
      @(negedge clk); r = Read;
      @(posedge clk); #1;
      t++;
    end while (!r && t < 50);
    if (!r) chk("byte consume timeout", {31'd0, r}, 32'd1);
    Empty = 1'b1;
  endtask

  task automatic pkt(input logic [7:0] op, input logic [7:0] ah, input logic [7:0] al);
    push(8'hA5); push(op); push(ah); push(al); push(op ^ ah ^ al);
  endtask

  task automatic frame(input logic [2:0] old_v, input logic [2:0] new_v);
    VSync = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("cfg one cycle after VSync", {29'd0, cfg()}, {29'd0, old_v});
    @(negedge clk); chk("cfg two cycles after VSync", {29'd0, cfg()}, {29'd0, new_v});
    @(posedge clk); #1 VSync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int idle;
    logic got;
    // Reset state, with a byte waiting so Read must still be held low
    Empty = 1'b0; RXD_Data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset Read", {31'd0, Read}, 32'd0);
    chk("reset Busy", {31'd0, Busy}, 32'd0);
    chk("reset Mem_WE", {31'd0, Mem_WE}, 32'd0);
    chk("reset Err", {31'd0, Err}, 32'd0);
    chk("reset cfg", {29'd0, cfg()}, 32'd0);
    chk("reset Mem_Addr", {20'd0, Mem_Addr}, 32'd0);
    chk("reset Mem_Data", {24'd0, Mem_Data}, 32'd0);
    Empty = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Config staging
    pkt(8'h01, 8'h00, 8'h05);
    chk("cfg staged, not applied", {29'd0, cfg()}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("cfg still held", {29'd0, cfg()}, 32'd0);
    frame(3'b000, 3'b101);

    // Address and write, auto-increment
    pkt(8'h02, 8'h00, 8'h10);
    wq.push_back('{a: 12'h010, d: 8'h7E});
    pkt(8'h03, 8'h00, 8'h7E);
    wq.push_back('{a: 12'h011, d: 8'h33});
    pkt(8'h03, 8'h00, 8'h33);

    // Wrap-around
    pkt(8'h02, 8'h0F, 8'hFF);
    wq.push_back('{a: 12'hFFF, d: 8'hAA});
    pkt(8'h03, 8'h00, 8'hAA);
    wq.push_back('{a: 12'h000, d: 8'h55});
    pkt(8'h03, 8'h00, 8'h55);

    // Resync + checksum error, then a good write at pointer 0x001
    eq.push_back(1);
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h03);
    push(8'h00); push(8'h11); push(8'h00);
    @(negedge clk); chk("Busy after bad CHK", {31'd0, Busy}, 32'd0);
    @(posedge clk); #1;
    wq.push_back('{a: 12'h001, d: 8'h44});
    pkt(8'h03, 8'h00, 8'h44);

    // Timeout inside a packet
    push(8'hA5); push(8'h01);
    chk("Busy mid-packet", {31'd0, Busy}, 32'd1);
    eq.push_back(1);
    idle = 0; got = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      @(negedge clk);
      if (Err) got = 1'b1;
      else idle++;
    end
    chk("timeout Err seen", {31'd0, got}, 32'd1);
    chk("timeout after ~1023 idle", {31'd0, (idle >= 1000 && idle <= 1030)}, 32'd1);
    chk("Busy after timeout", {31'd0, Busy}, 32'd0);
    @(posedge clk); #1;
    wq.push_back('{a: 12'h002, d: 8'h10});
    pkt(8'h03, 8'h00, 8'h10);

    // Reset mid-packet: no write, no Err, pointer and config cleared
    push(8'hA5); push(8'h02);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("Busy after rst", {31'd0, Busy}, 32'd0);
    chk("cfg after rst", {29'd0, cfg()}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    wq.push_back('{a: 12'h000, d: 8'h21});
    pkt(8'h03, 8'h00, 8'h21);

    // CFG CHK consumed in the same cycle as the frame edge
    pkt(8'h01, 8'h00, 8'h01);
    frame(3'b000, 3'b001);
    push(8'hA5); push(8'h01); push(8'h00);
    VSync = 1'b1;
    push(8'h06); push(8'h07);
    @(negedge clk); chk("old cfg on coincident edge", {29'd0, cfg()}, 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("new cfg waits for next frame", {29'd0, cfg()}, 32'd1);
    VSync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    frame(3'b001, 3'b110);

    repeat (4) @(posedge clk);
    #1;
    chk("pending writes", wq.size(), 32'd0);
    chk("pending errors", eq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
